gate_vector_seq: RTL and testbench

GATE_VECTOR_SEQ -- requirements
Module: gate_vector_seq

---
 rtl/gate_seq_pkg.sv | 19 +
 rtl/gate_settle_timer.sv | 26 ++
 rtl/gate_vector_seq.sv | 96 +++++++++
 tb/tb_gate_vector_seq.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/gate_seq_pkg.sv
// rtl/gate_seq_pkg.sv - shared constants, state encoding and helpers for the gate vector sequencer
package gate_seq_pkg;

  localparam int NUM_VEC = 4;
  localparam int IDX_W   = 2;
  localparam int ERR_W   = 3;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_APPLY = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_CHECK = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // Error count stops at NUM_VEC so it can never wrap.
  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (v >= ERR_W'(NUM_VEC)) ? v : v + ERR_W'(1);
  endfunction

endpackage

// File: rtl/gate_settle_timer.sv
// rtl/gate_settle_timer.sv - settle down-counter; load in APPLY, tick in WAIT
module gate_settle_timer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic [3:0] load_val,
  input  logic       tick,
  output logic       zero
);

  logic [3:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= 4'd0;
    end else if (load) begin
      cnt <= load_val;
    end else if (tick && (cnt != 4'd0)) begin
      cnt <= cnt - 4'd1;
    end
  end

  // Asserted on the last ticking cycle so WAIT spans exactly the loaded count.
  assign zero = (cnt <= 4'd1);

endmodule

// File: rtl/gate_vector_seq.sv
// rtl/gate_vector_seq.sv - 2-input gate truth-table checker; optional GATE_VECTOR_FAIL_MASK_EN builds the per-vector fail mask
module gate_vector_seq
  import gate_seq_pkg::*;
#(
  parameter int          SETTLE = 1,
  parameter logic [3:0]  EXPECT = 4'b1000
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic             x,
  output logic             y,
  input  logic             s_in,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_cnt,
  output logic [IDX_W-1:0] vec_idx,
  output logic [3:0]       fail_mask
);

  localparam logic [3:0]       SETTLE_V = 4'(SETTLE);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);

  logic [2:0] state;
  logic [2:0] nxt;
  logic       settle_zero;
  logic       restart;
  logic       mismatch;

  gate_settle_timer u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state == ST_APPLY),
    .load_val (SETTLE_V),
    .tick     (state == ST_WAIT),
    .zero     (settle_zero)
  );

  assign restart  = start && ((state == ST_IDLE) || (state == ST_DONE));
  assign mismatch = (s_in != EXPECT[vec_idx]);

  always_comb begin
    nxt = state;
    case (state)
      ST_IDLE:  if (start) nxt = ST_APPLY;
      ST_APPLY: nxt = (SETTLE_V != 4'd0) ? ST_WAIT : ST_CHECK;
      ST_WAIT:  if (settle_zero) nxt = ST_CHECK;
      ST_CHECK: nxt = (vec_idx == LAST_IDX) ? ST_DONE : ST_APPLY;
      ST_DONE:  if (start) nxt = ST_APPLY;
      default:  nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      vec_idx <= '0;
      err_cnt <= '0;
    end else begin
      state <= nxt;
      if (restart) begin
        vec_idx <= '0;
        err_cnt <= '0;
      end else if (state == ST_CHECK) begin
        if (mismatch) err_cnt <= sat_inc(err_cnt);
        if (vec_idx != LAST_IDX) vec_idx <= vec_idx + IDX_W'(1);
      end
    end
  end

`ifdef GATE_VECTOR_FAIL_MASK_EN
  logic [3:0] mask_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mask_q <= 4'd0;
    end else if (restart) begin
      mask_q <= 4'd0;
    end else if ((state == ST_CHECK) && mismatch) begin
      mask_q[vec_idx] <= 1'b1;
    end
  end

  assign fail_mask = mask_q;
`else
  assign fail_mask = 4'd0;
`endif

  assign busy = (state == ST_APPLY) || (state == ST_WAIT) || (state == ST_CHECK);
  assign done = (state == ST_DONE);
  assign pass = done && (err_cnt == '0);
  assign x    = busy & vec_idx[1];
  assign y    = busy & vec_idx[0];

endmodule

// File: tb/tb_gate_vector_seq.sv
// tb/tb_gate_vector_seq.sv - directed-vector bench for gate_vector_seq at SETTLE=1 and SETTLE=0
module tb_gate_vector_seq;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  int   mode = 0;

  logic       x1, y1, s1, busy1, done1, pass1;
  logic [2:0] err1;
  logic [1:0] idx1;
  logic [3:0] mask1;
  logic       x0, y0, s0, busy0, done0, pass0;
  logic [2:0] err0;
  logic [1:0] idx0;
  logic [3:0] mask0;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Gate models: 0 = AND, 1 = output stuck at 0, 2 = NAND.
  function automatic logic gate_model(input int m, input logic a, input logic b);
    case (m)
      0:       return a & b;
      1:       return 1'b0;
      default: return ~(a & b);
    endcase
  endfunction

  assign s1 = gate_model(mode, x1, y1);
  assign s0 = gate_model(mode, x0, y0);

  gate_vector_seq #(.SETTLE(1), .EXPECT(4'b1000)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x1), .y(y1), .s_in(s1),
    .busy(busy1), .done(done1), .pass(pass1), .err_cnt(err1),
    .vec_idx(idx1), .fail_mask(mask1)
  );

  gate_vector_seq #(.SETTLE(0), .EXPECT(4'b1000)) dut0 (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x0), .y(y0), .s_in(s0),
    .busy(busy0), .done(done0), .pass(pass0), .err_cnt(err0),
    .vec_idx(idx0), .fail_mask(mask0)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Starts a run; k counts edges after the first APPLY edge (k=0 is the APPLY cycle).
  task automatic run(input bit poke, output int c1, output int c0, output logic [7:0] seq,
                     output logic [2:0] err_at0, output logic [3:0] mask_at0);
    c1 = -1;
    c0 = -1;
    seq = 8'h00;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    err_at0 = err1;
    mask_at0 = mask1;
    for (int k = 0; k < 40; k++) begin
      if ((k % 3 == 0) && (k < 12)) seq[7 - 2 * (k / 3) -: 2] = {x1, y1};
      if (poke && k == 4) start = 1'b1;
      if (poke && k == 5) start = 1'b0;
      if (done1 && c1 < 0) c1 = k;
      if (done0 && c0 < 0) c0 = k;
      if (c1 >= 0 && c0 >= 0) break;
      @(posedge clk);
      #1;
    end
  endtask

  int         c1, c0;
  logic [7:0] seq;
  logic [2:0] e_at0;
  logic [3:0] m_at0;
  logic [3:0] exp_mask_one;
  logic [3:0] exp_mask_all;

  initial begin
`ifdef GATE_VECTOR_FAIL_MASK_EN
    exp_mask_one = 4'b1000;
    exp_mask_all = 4'b1111;
`else
    exp_mask_one = 4'b0000;
    exp_mask_all = 4'b0000;
`endif

    repeat (2) @(posedge clk);
    #1;
    check("rst_outs", {x1, y1, busy1, done1, pass1, err1, idx1, mask1}, 32'd0);
    check("rst_outs0", {x0, y0, busy0, done0, pass0, err0, idx0, mask0}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Good AND gate
    mode = 0;
    run(1'b0, c1, c0, seq, e_at0, m_at0);
    check("and_cycles", c1, 12);
    check("and_cycles_s0", c0, 8);
    check("and_seq", seq, 8'h1B);
    check("and_res", {pass1, err1, mask1}, {1'b1, 3'd0, 4'd0});
    check("and_res_s0", {pass0, err0, mask0}, {1'b1, 3'd0, 4'd0});
    check("and_xy_done", {x1, y1, busy1}, 3'd0);

    // Stuck-at-0 output, with a start pulse while busy
    mode = 1;
    run(1'b1, c1, c0, seq, e_at0, m_at0);
    check("st0_cycles", c1, 12);
    check("st0_cycles_s0", c0, 8);
    check("st0_res", {pass1, err1}, {1'b0, 3'd1});
    check("st0_mask", mask1, exp_mask_one);
    check("st0_res_s0", {pass0, err0, mask0}, {1'b0, 3'd1, exp_mask_one});
    repeat (5) @(posedge clk);
    #1;
    check("done_hold", {done1, err1, mask1, idx1}, {1'b1, 3'd1, exp_mask_one, 2'd3});

    // NAND: every vector mismatches; restart from DONE clears old results
    mode = 2;
    run(1'b0, c1, c0, seq, e_at0, m_at0);
    check("restart_clr", {e_at0, m_at0}, 7'd0);
    check("nand_cycles", c1, 12);
    check("nand_res", {pass1, err1}, {1'b0, 3'd4});
    check("nand_mask", mask1, exp_mask_all);
    check("nand_res_s0", {pass0, err0, mask0}, {1'b0, 3'd4, exp_mask_all});

    // Reset during WAIT of vector 2
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (7) @(posedge clk);
    #1;
    check("mid_state", {busy1, idx1, err1, x1, y1}, {1'b1, 2'd2, 3'd2, 1'b1, 1'b0});
    rst_n = 1'b0;
    #1;
    check("mid_rst_outs", {x1, y1, busy1, done1, pass1, err1, idx1, mask1}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    mode = 0;
    run(1'b0, c1, c0, seq, e_at0, m_at0);
    check("post_rst_cycles", c1, 12);
    check("post_rst_seq", seq, 8'h1B);
    check("post_rst_res", {pass1, err1, mask1}, {1'b1, 3'd0, 4'd0});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
